// File: rtl/rca_64_bit_if.sv
// Operand/result bundle for the 64-bit ripple-carry adder.
// Master drives a/b/c_in each cycle; slave returns the registered s/c_out one cycle later, no backpressure.
interface rca_64_bit_if;
    logic [63:0] a;
    logic [63:0] b;
    logic        c_in;
    logic [63:0] s;
    logic        c_out;

    modport master (
        output a,
        output b,
        output c_in,
        input  s,
        input  c_out
    );

    modport slave (
        input  a,
        input  b,
        input  c_in,
        output s,
        output c_out
    );
endinterface

// File: rtl/rca_64_bit.sv
// 64-bit ripple-carry adder, structural full-adder chain feeding registered {c_out, s}.
// Latency 1 cycle, one operation accepted every cycle, no backpressure.
module rca_64_bit_fa (
    input  logic x_i,
    input  logic y_i,
    input  logic ci_i,
    output logic sum_o,
    output logic co_o
);
    assign sum_o = x_i ^ y_i ^ ci_i;
    assign co_o  = (x_i & y_i) | (x_i & ci_i) | (y_i & ci_i);
endmodule

module rca_64_bit (
    input  logic         clk,
    input  logic         rst,
    rca_64_bit_if.slave  bus
);
    logic [64:0] carry;
    logic [63:0] s_d;
    logic [63:0] s_q;
    logic        c_out_d;
    logic        c_out_q;

    assign carry[0] = bus.c_in;

    // Carry ripples cell to cell; the full chain is the critical path into c_out_q.
    for (genvar i = 0; i < 64; i++) begin : g_cell
        rca_64_bit_fa u_fa (
            .x_i   (bus.a[i]),
            .y_i   (bus.b[i]),
            .ci_i  (carry[i]),
            .sum_o (s_d[i]),
            .co_o  (carry[i+1])
        );
    end

    assign c_out_d = carry[64];

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= 64'd0;
            c_out_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            c_out_q <= c_out_d;
        end
    end

    assign bus.s     = s_q;
    assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_rca_64_bit.sv
// Scoreboard bench: stimulus pushes expected {c_out, s} per issued cycle, monitor pops after each edge.
module tb_rca_64_bit;
    logic clk;
    logic rst;

    rca_64_bit_if bus ();

    rca_64_bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] s;
        logic        c;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_issued = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs away from the rising edge and record what that edge must produce.
    task automatic issue(input logic r, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic [63:0] es, input logic ec);
        exp_t e;
        @(negedge clk);
        rst      = r;
        bus.a    = a;
        bus.b    = b;
        bus.c_in = ci;
        e.s  = es;
        e.c  = ec;
        e.id = n_issued;
        n_issued++;
        exp_q.push_back(e);
    endtask

    task automatic issue_model(input logic r, input logic [63:0] a, input logic [63:0] b,
                               input logic ci);
        logic [64:0] full;
        full = {1'b0, a} + {1'b0, b} + {64'd0, ci};
        if (r) full = 65'd0;
        issue(r, a, b, ci, full[63:0], full[64]);
    endtask

    // Monitor: one result per rising edge once stimulus has started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_total++;
                if (bus.s === e.s && bus.c_out === e.c) begin
                    n_pass++;
                end else begin
                    $display("FAIL vec%0d: got s=%h c_out=%b, expected s=%h c_out=%b",
                             e.id, bus.s, bus.c_out, e.s, e.c);
                end
            end
        end
    end

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        logic        rr;

        rst      = 1'b1;
        bus.a    = '0;
        bus.b    = '0;
        bus.c_in = 1'b0;

        // Reset held two edges with all-ones operands, then released.
        issue(1'b1, ONES, ONES, 1'b1, 64'd0, 1'b0);
        issue(1'b1, ONES, ONES, 1'b1, 64'd0, 1'b0);
        issue(1'b0, ONES, ONES, 1'b1, ONES, 1'b1);

        // Decimal sums, back-to-back.
        issue(1'b0, 64'd84935734758545, 64'd98765432198765, 1'b1, 64'd183701166957311, 1'b0);
        issue(1'b0, 64'd45743957434588, 64'd98765432198765, 1'b0, 64'd144509389633353, 1'b0);

        // Full ripple cases.
        issue(1'b0, ONES, 64'd0, 1'b1, 64'd0, 1'b1);
        issue(1'b0, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'd0, 1'b1);
        issue(1'b0, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, ONES, 1'b0);

        // Large operand and top-bit carry.
        issue(1'b0, 64'd6891146489038534515, 64'd5, 1'b1, 64'd6891146489038534521, 1'b0);
        issue(1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1);

        // Small hand vectors exercising single carries and zero.
        issue(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0);
        issue(1'b0, 64'd0, 64'd0, 1'b1, 64'd1, 1'b0);
        issue(1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0);
        issue(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
              64'h2222_2222_2222_2211, 1'b0);

        // Mid-stream reset discards the sampled operation; next edge loads current inputs.
        issue(1'b1, ONES, 64'd7, 1'b1, 64'd0, 1'b0);
        issue(1'b0, ONES, 64'd7, 1'b1, 64'd7, 1'b1);

        // Random regression with sporadic reset pulses and forced full ripples.
        for (int i = 0; i < 10000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) begin
                rb = ~ra;
                rc = 1'b1;
            end
            issue_model(rr, ra, rb, rc);
        end

        // Let the last results drain, bounded, then confirm every expectation was consumed.
        repeat (3) @(negedge clk);
        n_total++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
